// File: rtl/demux_pkg.sv
// demux_pkg: shared lane-count constants, lane index type and round-robin step
package demux_pkg;
  localparam int NUM_LANES = 4;
  localparam int SEL_W = 2;
  typedef logic [SEL_W-1:0] lane_idx_t;
  function automatic lane_idx_t next_lane(lane_idx_t l);
    return l + lane_idx_t'(1);
  endfunction
endpackage

// File: rtl/demux_lane_slot.sv
// demux_lane_slot: one-entry holding register for a single output lane
module demux_lane_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              can_write
);
  assign can_write = !rd_valid || rd_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (wr_en) begin
      rd_valid <= 1'b1;
      rd_data  <= wr_data;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
endmodule

// File: rtl/demux_1to4_stream.sv
// demux_1to4_stream: registered 1-to-4 stream demux with select or round-robin routing
module demux_1to4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SEL_W-1:0]              sel,
  input  logic                          auto_mode,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic [NUM_LANES-1:0]          out_valid,
  input  logic [NUM_LANES-1:0]          out_ready,
  output logic [SEL_W-1:0]              rr_ptr,
  output logic [CNT_W-1:0]              beat_cnt
);
  lane_idx_t tgt;
  logic [NUM_LANES-1:0] can_write;
  logic acc;
  assign tgt = auto_mode ? rr_ptr : sel;
  assign in_ready = can_write[tgt];
  assign acc = in_valid && in_ready;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux_lane_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (acc && tgt == lane_idx_t'(k)),
      .wr_data   (in_data),
      .rd_ready  (out_ready[k]),
      .rd_valid  (out_valid[k]),
      .rd_data   (out_data[k*DATA_W +: DATA_W]),
      .can_write (can_write[k])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (acc) begin
      rr_ptr   <= auto_mode ? next_lane(rr_ptr) : rr_ptr;
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
endmodule
